// File: rtl/clod_pim_match_reducer_if.sv
// Row-in / result-out handshake bundle between the PiM match logic, the reducer and the
// PiM controller.
interface clod_pim_match_reducer_if #(
  parameter int unsigned NUM_ROW_ELEMENTS = 256
);
  localparam int unsigned IDX_W = (NUM_ROW_ELEMENTS > 1) ? $clog2(NUM_ROW_ELEMENTS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_ROW_ELEMENTS + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_ROW_ELEMENTS-1:0] match_bits;
  logic                        first_only;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic                        any_hit;
  logic [IDX_W-1:0]            first_idx;
  logic [CNT_W-1:0]            hit_count;

  // Producer of rows and consumer of results.
  modport master (
    output in_valid, match_bits, first_only, out_ready,
    input  in_ready, busy, out_valid, any_hit, first_idx, hit_count
  );

  // The reducer itself.
  modport slave (
    input  in_valid, match_bits, first_only, out_ready,
    output in_ready, busy, out_valid, any_hit, first_idx, hit_count
  );
endinterface

// File: rtl/clod_pim_match_reducer.sv
// Segment-serial reduction of a PiM match row into any-hit, lowest hit index and hit count,
// with optional stop at the first segment that contains a hit.
module clod_pim_match_reducer #(
  parameter int unsigned NUM_ROW_ELEMENTS = 256,
  parameter int unsigned SEG_WIDTH        = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  clod_pim_match_reducer_if.slave bus
);
  localparam int unsigned NUM_SEGS  = NUM_ROW_ELEMENTS / SEG_WIDTH;
  localparam int unsigned IDX_W     = (NUM_ROW_ELEMENTS > 1) ? $clog2(NUM_ROW_ELEMENTS) : 1;
  localparam int unsigned CNT_W     = $clog2(NUM_ROW_ELEMENTS + 1);
  localparam int unsigned SEG_IDX_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam int unsigned LOW_W     = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;
  localparam logic [SEG_IDX_W-1:0] LastSeg = SEG_IDX_W'(NUM_SEGS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                      state_q;
  logic [NUM_ROW_ELEMENTS-1:0] row_q;
  logic                        first_only_q;
  logic [SEG_IDX_W-1:0]        seg_q;
  logic                        any_hit_q;
  logic [IDX_W-1:0]            first_idx_q;
  logic [CNT_W-1:0]            hit_count_q;
  logic                        in_ready_q;
  logic                        busy_q;
  logic                        out_valid_q;

  logic [SEG_WIDTH-1:0] seg_bits;
  logic                 seg_hit;
  logic [CNT_W-1:0]     seg_pop;
  logic [LOW_W-1:0]     seg_low;
  logic [IDX_W-1:0]     hit_idx;

  always_comb begin
    seg_bits = row_q[seg_q*SEG_WIDTH +: SEG_WIDTH];
    seg_hit  = |seg_bits;
    seg_pop  = '0;
    seg_low  = '0;
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = int'(SEG_WIDTH) - 1; i >= 0; i--) begin
      if (seg_bits[i]) seg_low = LOW_W'(i);
    end
    for (int i = 0; i < int'(SEG_WIDTH); i++) begin
      seg_pop = seg_pop + CNT_W'(seg_bits[i]);
    end
    hit_idx = IDX_W'(32'(seg_q) * SEG_WIDTH + 32'(seg_low));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      first_only_q <= 1'b0;
      seg_q        <= '0;
      any_hit_q    <= 1'b0;
      first_idx_q  <= '0;
      hit_count_q  <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            row_q        <= bus.match_bits;
            first_only_q <= bus.first_only;
            seg_q        <= '0;
            any_hit_q    <= 1'b0;
            first_idx_q  <= '0;
            hit_count_q  <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StScan;
          end
        end
        StScan: begin
          hit_count_q <= hit_count_q + seg_pop;
          if (seg_hit && !any_hit_q) begin
            any_hit_q   <= 1'b1;
            first_idx_q <= hit_idx;
          end
          if (seg_q == LastSeg || (first_only_q && seg_hit)) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            seg_q <= seg_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.any_hit   = any_hit_q;
  assign bus.first_idx = first_idx_q;
  assign bus.hit_count = hit_count_q;

endmodule
